switch_debounce: RTL and testbench



---
 rtl/minisys_io_pkg.sv | 41 ++++
 rtl/debounce_bit.sv | 77 +++++++
 rtl/switch_debounce.sv | 76 +++++++
 tb/tb_switch_debounce.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_io_pkg.sv
// Shared constants and helpers for the minisys board I/O conditioning blocks
// (switches now; LEDs and keypad later reuse the same timing defaults).
package minisys_io_pkg;

    // Number of board DIP switches.
    localparam int SW_WIDTH = 16;

    // Default debounce timing: CPU cycles per sample tick, and the number of
    // consecutive differing samples needed before a new level is accepted.
    localparam int SW_TICK_DIV_DEF = 25000;
    localparam int SW_STABLE_N_DEF = 8;

    // What a single debounce bit does in a given cycle.
    typedef enum logic [1:0] {
        DB_HOLD    = 2'b00,  // no sample tick: everything keeps its value
        DB_RESTART = 2'b01,  // sample matches the accepted level: restart count
        DB_COUNT   = 2'b10,  // sample differs, not yet long enough: count it
        DB_ACCEPT  = 2'b11   // sample differed for the full window: take it
    } db_action_e;

    // Decide the debounce action from the tick, the level comparison and
    // whether the counter already holds the last-but-one differing sample.
    function automatic db_action_e db_action(
        input logic tick,
        input logic differ,
        input logic at_limit
    );
        db_action_e act;
        if (!tick) begin
            act = DB_HOLD;
        end else if (!differ) begin
            act = DB_RESTART;
        end else if (at_limit) begin
            act = DB_ACCEPT;
        end else begin
            act = DB_COUNT;
        end
        return act;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, accepted
// level and a one-cycle change pulse aligned with the level update.
module debounce_bit
    import minisys_io_pkg::*;
#(
    parameter int STABLE_N = SW_STABLE_N_DEF,
    parameter int CNT_W    = $clog2(STABLE_N + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             pulse_r;
    db_action_e       act_s;

    // Classify this cycle from the synchronised sample and the accepted level.
    always_comb begin
        act_s = db_action(tick, (sync2_r != level_r), (cnt_r == CNT_LAST));
    end

    // Bring the asynchronous pad into the clock domain; only sync2_r is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive differing ticks; accept the new level on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= 1'b0;
            case (act_s)
                DB_HOLD: begin
                    cnt_r <= cnt_r;
                end
                DB_RESTART: begin
                    cnt_r <= CNT_ZERO;
                end
                DB_COUNT: begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
                DB_ACCEPT: begin
                    cnt_r   <= CNT_ZERO;
                    level_r <= sync2_r;
                    pulse_r <= 1'b1;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign level = level_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/switch_debounce.sv
// Switch front end: shared debounce sample prescaler, one debounce_bit per
// switch, and sticky per-bit change flags with a software clear strobe.
module switch_debounce
    import minisys_io_pkg::*;
#(
    parameter int WIDTH    = SW_WIDTH,
    parameter int TICK_DIV = SW_TICK_DIV_DEF,
    parameter int STABLE_N = SW_STABLE_N_DEF,
    parameter int CNT_W    = $clog2(STABLE_N + 1)
) (
    input  logic             swdbclk,
    input  logic             swdbrst,
    input  logic [WIDTH-1:0] switch_raw,
    input  logic [WIDTH-1:0] chg_clr,
    output logic [WIDTH-1:0] switch_o,
    output logic [WIDTH-1:0] change_p,
    output logic [WIDTH-1:0] changed
);

    // A divider of 1 still needs a one-bit counter that simply stays at 0.
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] pulse_s;
    logic [WIDTH-1:0] changed_r;

    // The sample tick fires in the last cycle of each prescaler period.
    always_comb begin
        tick_s = (pre_r == PRE_LAST);
    end

    // Free-running prescaler 0..TICK_DIV-1.
    always_ff @(posedge swdbclk or posedge swdbrst) begin
        if (swdbrst) begin
            pre_r <= PRE_ZERO;
        end else if (tick_s) begin
            pre_r <= PRE_ZERO;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // One independent debounce channel per switch, all sharing the tick.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_N (STABLE_N),
            .CNT_W    (CNT_W)
        ) u_bit (
            .clk   (swdbclk),
            .rst   (swdbrst),
            .tick  (tick_s),
            .raw   (switch_raw[i]),
            .level (level_s[i]),
            .pulse (pulse_s[i])
        );
    end

    // Sticky change flags: a pulse sets, the clear strobe clears, set wins.
    always_ff @(posedge swdbclk or posedge swdbrst) begin
        if (swdbrst) begin
            changed_r <= {WIDTH{1'b0}};
        end else begin
            changed_r <= (changed_r & ~chg_clr) | pulse_s;
        end
    end

    assign switch_o = level_s;
    assign change_p = pulse_s;
    assign changed  = changed_r;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with TICK_DIV=4, STABLE_N=3: directed scenarios
// with literal expectations plus randomized bouncing inputs, all compared
// every cycle against a sample-history reference model.
module tb_switch_debounce;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int SN = 3;

    logic          swdbclk    = 1'b0;
    logic          swdbrst    = 1'b1;
    logic [W-1:0]  switch_raw = 16'h0000;
    logic [W-1:0]  chg_clr    = 16'h0000;
    logic [W-1:0]  switch_o;
    logic [W-1:0]  change_p;
    logic [W-1:0]  changed;

    int tests = 0;
    int fails = 0;

    switch_debounce #(
        .WIDTH    (W),
        .TICK_DIV (TD),
        .STABLE_N (SN)
    ) dut (
        .swdbclk    (swdbclk),
        .swdbrst    (swdbrst),
        .switch_raw (switch_raw),
        .chg_clr    (chg_clr),
        .switch_o   (switch_o),
        .change_p   (change_p),
        .changed    (changed)
    );

    always #5 swdbclk = ~swdbclk;

    // ---------------- reference model ----------------
    // Raw values reach the debouncer two clock edges late; a sample is taken
    // whenever the number of edges since reset is one less than a multiple of
    // TD; a bit flips when its last SN samples all differ from its level.
    logic [W-1:0] m_lvl     = 16'h0000;
    logic [W-1:0] m_pulse   = 16'h0000;
    logic [W-1:0] m_changed = 16'h0000;
    int           m_n       = 0;
    logic [W-1:0] m_delay[$];
    logic [W-1:0] m_hist[$];

    function automatic void model_clear();
        m_lvl     = 16'h0000;
        m_pulse   = 16'h0000;
        m_changed = 16'h0000;
        m_n       = 0;
        m_delay   = '{16'h0000, 16'h0000};
        m_hist    = {};
    endfunction

    function automatic void model_step();
        logic [W-1:0] smp;
        logic [W-1:0] nxt_lvl;
        logic [W-1:0] nxt_pulse;
        logic         all_diff;
        smp = m_delay.pop_front();
        m_delay.push_back(switch_raw);
        m_changed = (m_changed & ~chg_clr) | m_pulse;
        nxt_lvl   = m_lvl;
        nxt_pulse = 16'h0000;
        if ((m_n % TD) == (TD - 1)) begin
            m_hist.push_back(smp);
            if (m_hist.size() > SN) begin
                void'(m_hist.pop_front());
            end
            if (m_hist.size() == SN) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k]) begin
                        if (m_hist[k][b] == m_lvl[b]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        nxt_lvl[b]   = ~m_lvl[b];
                        nxt_pulse[b] = 1'b1;
                    end
                end
            end
        end
        m_lvl   = nxt_lvl;
        m_pulse = nxt_pulse;
        m_n     = m_n + 1;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge swdbclk or posedge swdbrst);
            if (swdbrst) model_clear();
            else         model_step();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge swdbclk);
            check("model_switch_o", switch_o, m_lvl);
            check("model_change_p", change_p, m_pulse);
            check("model_changed",  changed,  m_changed);
        end
    end

    task automatic do_reset();
        @(negedge swdbclk);
        #2 swdbrst = 1'b1;
        repeat (2) @(negedge swdbclk);
        #2 swdbrst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int           lat;
    int           bad;
    int           pulses0;
    int           noisy_den;
    logic [W-1:0] mask;

    initial begin
        repeat (3) @(negedge swdbclk);
        check("reset_switch_o", switch_o, 16'h0000);
        check("reset_change_p", change_p, 16'h0000);
        check("reset_changed",  changed,  16'h0000);
        swdbrst = 1'b0;

        // Clean rise on bit 0.
        @(negedge swdbclk);
        switch_raw = 16'h0001;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge swdbclk);
            if (switch_o[0]) begin
                lat = k;
                break;
            end
        end
        check_range("rise_latency", lat, 11, 14);
        check("rise_pulse", change_p, 16'h0001);
        check("rise_model_level", m_lvl, 16'h0001);
        @(negedge swdbclk);
        check("rise_pulse_single", change_p, 16'h0000);
        check("rise_changed", changed, 16'h0001);

        // Glitch on bit 5 shorter than the stability window.
        switch_raw = 16'h0000;
        do_reset();
        switch_raw = 16'h0020;
        repeat (6) @(negedge swdbclk);
        switch_raw = 16'h0000;
        bad = 0;
        repeat (40) begin
            @(negedge swdbclk);
            if ((switch_o | change_p | changed) != 16'h0000) bad++;
        end
        check_range("glitch_nonzero_cycles", bad, 0, 0);
        check("glitch_model_level", m_lvl, 16'h0000);

        // Simultaneous multi-bit change.
        switch_raw = 16'hA5A5;
        for (int k = 0; k < 30; k++) begin
            @(negedge swdbclk);
            if (switch_o != 16'h0000) break;
        end
        check("multi_switch_o", switch_o, 16'hA5A5);
        check("multi_pulse", change_p, 16'hA5A5);
        @(negedge swdbclk);
        check("multi_pulse_single", change_p, 16'h0000);
        check("multi_changed", changed, 16'hA5A5);

        // Clear colliding with a new set on bit 1.
        switch_raw = 16'h0000;
        do_reset();
        switch_raw = 16'h00FF;
        for (int k = 0; k < 30; k++) begin
            @(negedge swdbclk);
            if (changed == 16'h00FF) break;
        end
        check("coll_setup_changed", changed, 16'h00FF);
        switch_raw = 16'h00FD;
        for (int k = 0; k < 30; k++) begin
            @(negedge swdbclk);
            if (m_pulse[1]) break;
        end
        chg_clr = 16'h00FF;
        @(negedge swdbclk);
        chg_clr = 16'h0000;
        check("coll_changed", changed, 16'h0002);

        // Reset in the middle of a count on bit 3.
        switch_raw = 16'h0000;
        do_reset();
        switch_raw = 16'h0001;
        for (int k = 0; k < 30; k++) begin
            @(negedge swdbclk);
            if (m_lvl == 16'h0001 && m_pulse == 16'h0000) break;
        end
        for (int k = 0; k < 8; k++) begin
            if ((m_n % TD) == 0) break;
            @(negedge swdbclk);
        end
        switch_raw = 16'h0009;
        repeat (9) @(negedge swdbclk);
        check("midcnt_before_reset", switch_o, 16'h0001);
        #1 swdbrst = 1'b1;
        #1;
        check("async_reset_switch_o", switch_o, 16'h0000);
        check("async_reset_change_p", change_p, 16'h0000);
        check("async_reset_changed",  changed,  16'h0000);
        repeat (2) @(negedge swdbclk);
        swdbrst = 1'b0;
        repeat (11) @(negedge swdbclk);
        check("post_reset_not_yet", switch_o, 16'h0000);
        @(negedge swdbclk);
        check("post_reset_rise", switch_o, 16'h0009);
        check("post_reset_pulse", change_p, 16'h0009);

        // Falling edge on bit 0 with a bounce.
        repeat (2) @(negedge swdbclk);
        pulses0 = 0;
        switch_raw = 16'h0008;
        for (int k = 0; k < 3; k++) begin
            @(negedge swdbclk);
            if (change_p[0]) pulses0++;
        end
        switch_raw = 16'h0009;
        for (int k = 0; k < 4; k++) begin
            @(negedge swdbclk);
            if (change_p[0]) pulses0++;
        end
        switch_raw = 16'h0008;
        for (int k = 0; k < 40; k++) begin
            @(negedge swdbclk);
            if (change_p[0]) pulses0++;
        end
        check_range("fall_pulse_count", pulses0, 1, 1);
        check("fall_switch_o", switch_o, 16'h0008);

        // Randomized bouncing switches, sparse clears and occasional resets.
        noisy_den = 4;
        for (int c = 0; c < 3000; c++) begin
            @(negedge swdbclk);
            if ((c % 64) == 0) noisy_den = ($urandom_range(0, 1) == 0) ? 4 : 64;
            if ($urandom_range(0, 599) == 0) do_reset();
            mask = 16'h0000;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, noisy_den - 1) == 0) mask[b] = 1'b1;
            end
            switch_raw = switch_raw ^ mask;
            chg_clr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0000;
        end
        chg_clr = 16'h0000;
        @(negedge swdbclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
